mario_tile_poller: RTL and testbench
====================================

Name: mario_tile_poller

Overview:
- Upstream feeder of the Mario movement block.
- Once per frame it reads the level tile map around Mario's current box and produces the four 3-bit neighbour tile codes that gate jumping, falling and walking: mario_poll_up, mario_poll_down, mario_poll_left, mario_poll_right.
- It also owns the horizontal level scroll column. The column advances on each Shift pulse and is shared with the background renderer.

Parameters:
- LEVEL_COLS, 256, tile columns in the level map (map address = {row[3:0], col[7:0]}).
- SCREEN_COLS, 10, visible tile columns.
- TILE, 40, tile edge in pixels.
- X_MIN, 120, playfield left pixel.
- X_MAX, 519, playfield right pixel.
- Y_MIN, 40, playfield top pixel.
- Y_MAX, 439, playfield bottom pixel.
- MARIO_SIZE, 20, Mario half-size; box spans X-20..X+19, Y-20..Y+19.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  asynchronous, active-low reset.
- frame_clk  in  1  frame tick (VS); edge-detected internally.
- Shift  in  1  one-Clk scroll request from Mario.
- Mario_X_Pos  in  10  Mario centre X.
- Mario_Y_Pos  in  10  Mario centre Y.
- map_rd  out  1  tile map read strobe.
- map_addr  out  12  tile map address {row, col}.
- map_data  in  3  tile code; valid exactly 1 Clk after map_rd.
- mario_poll_up  out  3  tile code above Mario, 0 = empty.
- mario_poll_down  out  3  tile code below Mario.
- mario_poll_left  out  3  tile code left of Mario.
- mario_poll_right  out  3  tile code right of Mario.
- scroll_col  out  8  level column shown at screen column 0.
- poll_valid  out  1  one-Clk pulse when the poll outputs update.
- busy  out  1  high while a poll sequence runs.

Behaviour:
- Reset (Reset=0, async):
  - All outputs 0: poll codes, scroll_col, map_rd, map_addr, poll_valid, busy.
  - FSM returns to IDLE.
  - A reset asserted mid-sequence abandons it with no publish.
- Edge detect: frame_delayed <= frame_clk; rise <= frame_clk & ~frame_delayed, both registered.
- Scroll:
  - Each Clk with Shift=1 increments scroll_col by 1.
  - scroll_col saturates at LEVEL_COLS-SCREEN_COLS (246); Shift at 246 leaves it at 246.
  - Scroll runs independently of the FSM.
- FSM, one probe per Clk:
  - IDLE: when rise=1, go to CAPTURE. busy=0.
  - CAPTURE: latch Mario_X_Pos, Mario_Y_Pos and scroll_col; compute the 8 probe points. Go to ISSUE with idx=0.
  - ISSUE, idx 0..7: drive map_addr and map_rd for probe idx; the result of probe idx-1 arrives this Clk. Go to DRAIN after idx 7.
  - DRAIN: receive probe 7. Go to PUBLISH.
  - PUBLISH: update the four poll outputs atomically and pulse poll_valid=1. Go to IDLE.
  - busy=1 in CAPTURE through PUBLISH.
  - Latency: rise high in cycle N gives poll_valid in cycle N+11.
  - A rise while busy is ignored; there is no queueing.
- Probe points, using latched values (L=X-20, R=X+19, T=Y-20, B=Y+19):
  - 0,1 up: (L,T-1), (R,T-1).
  - 2,3 down: (L,B+1), (R,B+1).
  - 4,5 left: (L-1,T), (L-1,B).
  - 6,7 right: (R+1,T), (R+1,B).
- Tile conversion:
  - col = scroll_col + (x-X_MIN)/TILE.
  - row = (y-Y_MIN)/TILE.
  - Divide with an unsigned compare chain over 0..9; no divider.
  - All arithmetic is 10-bit unsigned; underflow below X_MIN/Y_MIN counts as outside.
- Outside probes:
  - A probe with x<X_MIN, x>X_MAX, y<Y_MIN or y>Y_MAX issues no read (map_rd=0 that Clk).
  - Its result is forced to 0.
- Combine per direction: result = first probe's code if nonzero, else second probe's code. The first (left/top) probe wins when both are nonzero.
- The poll outputs hold their value between publishes.

Test Plan:
- Reset low mid-ISSUE with scroll_col=5 -> every output 0 immediately; after release with frame ticks, the next publish comes only from a fresh rise.
- All-zero map, X=220, Y=260, one frame rise in cycle N -> poll_valid in cycle N+11 only. All polls 0. Read addresses in order 0x402, 0x402, 0x602, 0x602, 0x501, 0x501, 0x503, 0x503.
- Same position, map[0x602]=1, map[0x501]=2 -> down=1, left=2, up=0, right=0.
- 3 Shift pulses, then a poll at X=220, Y=260 with map[0x605]=4 -> scroll_col=3, down=4. 250 more pulses -> scroll_col=246.
- X=140 (probe x=119 < X_MIN) with map[0x500]=7 -> no map_rd in the left-probe cycles, left=0.
- Up probes with map[0x402]=3 and X=240 so the right probe lands on col 3 with map[0x403]=5 -> up=3; a second frame rise while busy does not extend or restart the sequence.

Source files
------------

// File: rtl/mario_tile_poller.sv
// Per-frame neighbour-tile poller for the Mario movement block.
// Probes eight map points around Mario's box and owns the shared level scroll column.
module mario_tile_poller #(
    parameter int unsigned LEVEL_COLS  = 256,
    parameter int unsigned SCREEN_COLS = 10,
    parameter int unsigned TILE        = 40,
    parameter int unsigned X_MIN       = 120,
    parameter int unsigned X_MAX       = 519,
    parameter int unsigned Y_MIN       = 40,
    parameter int unsigned Y_MAX       = 439,
    parameter int unsigned MARIO_SIZE  = 20
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_clk,
    input  logic        Shift,
    input  logic [9:0]  Mario_X_Pos,
    input  logic [9:0]  Mario_Y_Pos,
    output logic        map_rd,
    output logic [11:0] map_addr,
    input  logic [2:0]  map_data,
    output logic [2:0]  mario_poll_up,
    output logic [2:0]  mario_poll_down,
    output logic [2:0]  mario_poll_left,
    output logic [2:0]  mario_poll_right,
    output logic [7:0]  scroll_col,
    output logic        poll_valid,
    output logic        busy
);

    localparam logic [7:0] ScrollMax = 8'(LEVEL_COLS - SCREEN_COLS);
    localparam logic [9:0] XMin      = 10'(X_MIN);
    localparam logic [9:0] XMax      = 10'(X_MAX);
    localparam logic [9:0] YMin      = 10'(Y_MIN);
    localparam logic [9:0] YMax      = 10'(Y_MAX);
    localparam logic [9:0] Half      = 10'(MARIO_SIZE);

    typedef enum logic [2:0] {StIdle, StCapture, StIssue, StDrain, StPublish} state_e;

    state_e      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [9:0]  x_q, x_d, y_q, y_d;
    logic [7:0]  scr_q, scr_d;
    logic [7:0]  scroll_q, scroll_d;
    logic        frame_delayed_q, rise_q;
    logic        prev_in_q, prev_in_d;
    logic        valid_q, valid_d;
    logic [2:0]  up_q, up_d, down_q, down_d, left_q, left_d, right_q, right_d;
    logic [2:0]  res_q [8];
    logic [2:0]  res_d [8];
    logic [2:0]  fin [8];

    logic [9:0]  lft, rgt, top, bot, px, py;
    logic        in_range;
    logic [3:0]  row;
    logic [7:0]  col;

    // Quotient of off/TILE over 0..9 via a compare chain instead of a divider.
    function automatic logic [3:0] tile_div(input logic [9:0] off);
        logic [3:0] q;
        q = '0;
        for (int k = 1; k <= 9; k++) begin
            if (off >= 10'(k * TILE)) q = 4'(k);
        end
        return q;
    endfunction

    always_comb begin
        lft = x_q - Half;
        rgt = x_q + Half - 10'd1;
        top = y_q - Half;
        bot = y_q + Half - 10'd1;
        px  = '0;
        py  = '0;
        unique case (idx_q)
            3'd0: begin px = lft;          py = top - 10'd1; end
            3'd1: begin px = rgt;          py = top - 10'd1; end
            3'd2: begin px = lft;          py = bot + 10'd1; end
            3'd3: begin px = rgt;          py = bot + 10'd1; end
            3'd4: begin px = lft - 10'd1;  py = top;         end
            3'd5: begin px = lft - 10'd1;  py = bot;         end
            3'd6: begin px = rgt + 10'd1;  py = top;         end
            3'd7: begin px = rgt + 10'd1;  py = bot;         end
        endcase
        // Wrapped underflow lands above the max bound, so it reads as outside too.
        in_range = (px >= XMin) && (px <= XMax) && (py >= YMin) && (py <= YMax);
        col      = scr_q + 8'(tile_div(px - XMin));
        row      = tile_div(py - YMin);
    end

    always_comb begin
        map_rd   = (state_q == StIssue) && in_range;
        map_addr = (state_q == StIssue) ? {row, col} : 12'd0;
        busy     = (state_q != StIdle);
    end

    always_comb begin
        scroll_d = scroll_q;
        if (Shift && (scroll_q < ScrollMax)) scroll_d = scroll_q + 8'd1;
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        x_d       = x_q;
        y_d       = y_q;
        scr_d     = scr_q;
        prev_in_d = prev_in_q;
        valid_d   = 1'b0;
        up_d      = up_q;
        down_d    = down_q;
        left_d    = left_q;
        right_d   = right_q;
        res_d     = res_q;
        fin       = res_q;
        unique case (state_q)
            StIdle: begin
                if (rise_q) state_d = StCapture;
            end
            StCapture: begin
                x_d     = Mario_X_Pos;
                y_d     = Mario_Y_Pos;
                scr_d   = scroll_q;
                idx_d   = 3'd0;
                state_d = StIssue;
            end
            StIssue: begin
                // Data returning now belongs to the probe issued last cycle.
                if (idx_q != 3'd0) begin
                    res_d[3'(idx_q - 3'd1)] = prev_in_q ? map_data : 3'd0;
                end
                prev_in_d = in_range;
                idx_d     = idx_q + 3'd1;
                if (idx_q == 3'd7) state_d = StDrain;
            end
            StDrain: begin
                fin[7]  = prev_in_q ? map_data : 3'd0;
                res_d   = fin;
                up_d    = (fin[0] != 3'd0) ? fin[0] : fin[1];
                down_d  = (fin[2] != 3'd0) ? fin[2] : fin[3];
                left_d  = (fin[4] != 3'd0) ? fin[4] : fin[5];
                right_d = (fin[6] != 3'd0) ? fin[6] : fin[7];
                valid_d = 1'b1;
                state_d = StPublish;
            end
            StPublish: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q         <= StIdle;
            idx_q           <= '0;
            x_q             <= '0;
            y_q             <= '0;
            scr_q           <= '0;
            scroll_q        <= '0;
            frame_delayed_q <= 1'b0;
            rise_q          <= 1'b0;
            prev_in_q       <= 1'b0;
            valid_q         <= 1'b0;
            up_q            <= '0;
            down_q          <= '0;
            left_q          <= '0;
            right_q         <= '0;
            res_q           <= '{default: '0};
        end else begin
            state_q         <= state_d;
            idx_q           <= idx_d;
            x_q             <= x_d;
            y_q             <= y_d;
            scr_q           <= scr_d;
            scroll_q        <= scroll_d;
            frame_delayed_q <= frame_clk;
            rise_q          <= frame_clk & ~frame_delayed_q;
            prev_in_q       <= prev_in_d;
            valid_q         <= valid_d;
            up_q            <= up_d;
            down_q          <= down_d;
            left_q          <= left_d;
            right_q         <= right_d;
            res_q           <= res_d;
        end
    end

    assign mario_poll_up    = up_q;
    assign mario_poll_down  = down_q;
    assign mario_poll_left  = left_q;
    assign mario_poll_right = right_q;
    assign scroll_col       = scroll_q;
    assign poll_valid       = valid_q;

endmodule

// File: tb/tb_mario_tile_poller.sv
// Directed bench for mario_tile_poller: tile map model, read-address log and
// hand-computed poll results, latencies and scroll values.
module tb_mario_tile_poller;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        frame_clk = 1'b0;
    logic        Shift = 1'b0;
    logic [9:0]  Mario_X_Pos = '0;
    logic [9:0]  Mario_Y_Pos = '0;
    logic        map_rd;
    logic [11:0] map_addr;
    logic [2:0]  map_data = '0;
    logic [2:0]  mario_poll_up, mario_poll_down, mario_poll_left, mario_poll_right;
    logic [7:0]  scroll_col;
    logic        poll_valid, busy;

    int checks = 0;
    int errors = 0;

    logic [2:0]  mem [4096];
    logic [11:0] addr_log [$];

    mario_tile_poller dut (
        .Clk              (Clk),
        .Reset            (Reset),
        .frame_clk        (frame_clk),
        .Shift            (Shift),
        .Mario_X_Pos      (Mario_X_Pos),
        .Mario_Y_Pos      (Mario_Y_Pos),
        .map_rd           (map_rd),
        .map_addr         (map_addr),
        .map_data         (map_data),
        .mario_poll_up    (mario_poll_up),
        .mario_poll_down  (mario_poll_down),
        .mario_poll_left  (mario_poll_left),
        .mario_poll_right (mario_poll_right),
        .scroll_col       (scroll_col),
        .poll_valid       (poll_valid),
        .busy             (busy)
    );

    always #5 Clk = ~Clk;

    // Map model: one-cycle read latency; junk when no read so ungated results show up.
    always @(posedge Clk) begin
        map_data <= map_rd ? mem[map_addr] : 3'd6;
        if (map_rd) addr_log.push_back(map_addr);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 4096; i++) mem[i] = 3'd0;
    endtask

    task automatic shift_n(input int n);
        @(negedge Clk);
        Shift = 1'b1;
        repeat (n) @(negedge Clk);
        Shift = 1'b0;
    endtask

    // k counts negedges after the one raising frame_clk; k=1 is the rise cycle.
    task automatic run_poll(input bit second, output int lat, output int npulse);
        lat = -1;
        npulse = 0;
        addr_log.delete();
        @(negedge Clk);
        frame_clk = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge Clk);
            if (poll_valid) begin
                npulse++;
                if (lat < 0) lat = k;
            end
            if (k == 1) frame_clk = 1'b0;
            if (second && k == 4) frame_clk = 1'b1;
            if (second && k == 5) frame_clk = 1'b0;
        end
    endtask

    function automatic logic [31:0] all_out();
        return 32'({map_rd, map_addr, mario_poll_up, mario_poll_down, mario_poll_left,
                    mario_poll_right, scroll_col, poll_valid, busy});
    endfunction

    int lat, np, cnt;
    logic [11:0] exp_addr [8];

    initial begin
        clear_mem();
        #1;
        check("reset_outputs", all_out(), 32'd0);
        repeat (2) @(negedge Clk);
        Reset = 1'b1;

        // Reset in the middle of a sequence
        Mario_X_Pos = 10'd220;
        Mario_Y_Pos = 10'd260;
        shift_n(5);
        check("scroll_5", 32'(scroll_col), 32'd5);
        mem[12'h602] = 3'd1;
        @(negedge Clk);
        frame_clk = 1'b1;
        @(negedge Clk);
        frame_clk = 1'b0;
        repeat (4) @(negedge Clk);
        check("busy_mid_issue", 32'(busy), 32'd1);
        #2 Reset = 1'b0;
        #1 check("async_reset_outputs", all_out(), 32'd0);
        repeat (2) @(negedge Clk);
        Reset = 1'b1;
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge Clk);
            if (poll_valid || busy) cnt++;
        end
        check("no_publish_after_reset", 32'(cnt), 32'd0);
        clear_mem();

        // All-zero map: latency and address order
        run_poll(1'b0, lat, np);
        check("latency_n11", 32'(lat), 32'd12);
        check("single_pulse", 32'(np), 32'd1);
        check("polls_zero", 32'({mario_poll_up, mario_poll_down, mario_poll_left,
                                 mario_poll_right}), 32'd0);
        exp_addr = '{12'h402, 12'h402, 12'h602, 12'h602, 12'h501, 12'h501, 12'h503, 12'h503};
        check("read_count", 32'(addr_log.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < addr_log.size()) check($sformatf("addr_%0d", i), 32'(addr_log[i]),
                                           32'(exp_addr[i]));
        end

        // Down and left hits
        mem[12'h602] = 3'd1;
        mem[12'h501] = 3'd2;
        run_poll(1'b0, lat, np);
        check("hit_up", 32'(mario_poll_up), 32'd0);
        check("hit_down", 32'(mario_poll_down), 32'd1);
        check("hit_left", 32'(mario_poll_left), 32'd2);
        check("hit_right", 32'(mario_poll_right), 32'd0);
        repeat (5) @(negedge Clk);
        check("polls_hold", 32'({mario_poll_down, mario_poll_left}), 32'({3'd1, 3'd2}));
        clear_mem();

        // Left probe outside the playfield
        Mario_X_Pos = 10'd140;
        mem[12'h500] = 3'd7;
        run_poll(1'b0, lat, np);
        check("outside_read_count", 32'(addr_log.size()), 32'd6);
        cnt = 0;
        foreach (addr_log[i]) if (addr_log[i] == 12'h500) cnt++;
        check("outside_no_read", 32'(cnt), 32'd0);
        check("outside_left", 32'(mario_poll_left), 32'd0);
        clear_mem();

        // Up probes straddle two columns; first wins; busy rise ignored
        Mario_X_Pos = 10'd240;
        mem[12'h402] = 3'd3;
        mem[12'h403] = 3'd5;
        run_poll(1'b1, lat, np);
        check("up_first_wins", 32'(mario_poll_up), 32'd3);
        check("busy_rise_latency", 32'(lat), 32'd12);
        check("busy_rise_one_pulse", 32'(np), 32'd1);
        check("busy_rise_reads", 32'(addr_log.size()), 32'd8);
        if (addr_log.size() > 1) check("up_right_addr", 32'(addr_log[1]), 32'h403);
        clear_mem();

        // Scroll offsets column; saturation
        Mario_X_Pos = 10'd220;
        shift_n(3);
        check("scroll_3", 32'(scroll_col), 32'd3);
        mem[12'h605] = 3'd4;
        run_poll(1'b0, lat, np);
        check("scroll_down", 32'(mario_poll_down), 32'd4);
        shift_n(242);
        check("scroll_245", 32'(scroll_col), 32'd245);
        shift_n(8);
        check("scroll_sat", 32'(scroll_col), 32'd246);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
